// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with registered one-hot grant and owner-driven release.
// Optional forced release after TIMEOUT_CYC grant cycles when ARB_TIMEOUT_EN is defined.
module rr_arbiter4 #(
  parameter int TIMEOUT_CYC = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] grant,
  output logic [1:0] grant_idx,
  output logic       grant_valid,
  output logic       timeout
);

  // state | meaning
  // IDLE  | no owner; arbitrate among req starting after last_idx
  // GRANT | grant_idx owns the resource until done, req drop or timeout
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t     state, state_nxt;
  logic [1:0] last_idx, last_idx_nxt;
  logic [3:0] grant_nxt;
  logic [1:0] grant_idx_nxt;
  logic       grant_valid_nxt;
  logic [1:0] sel_idx;
  logic       sel_found;
  logic       force_rel;

  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 15) begin : g_bad_timeout
    $error("rr_arbiter4: TIMEOUT_CYC must be within 2..15");
  end

  // Rotating search: offsets 1..4 from last_idx, so the previous owner is tried last.
  always_comb begin
    logic [1:0] cand;
    sel_idx   = 2'd0;
    sel_found = 1'b0;
    cand      = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_idx + 2'(k);
      if (!sel_found && req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    state_nxt       = state;
    grant_nxt       = grant;
    grant_idx_nxt   = grant_idx;
    grant_valid_nxt = grant_valid;
    last_idx_nxt    = last_idx;
    case (state)
      IDLE: begin
        if (sel_found) begin
          state_nxt       = GRANT;
          grant_nxt       = 4'b0001 << sel_idx;
          grant_idx_nxt   = sel_idx;
          grant_valid_nxt = 1'b1;
        end
      end
      GRANT: begin
        if (done || !req[grant_idx] || force_rel) begin
          state_nxt       = IDLE;
          grant_nxt       = 4'b0000;
          grant_idx_nxt   = 2'd0;
          grant_valid_nxt = 1'b0;
          last_idx_nxt    = grant_idx;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= 4'b0000;
      grant_idx   <= 2'd0;
      grant_valid <= 1'b0;
      last_idx    <= 2'd3;
    end else begin
      state       <= state_nxt;
      grant       <= grant_nxt;
      grant_idx   <= grant_idx_nxt;
      grant_valid <= grant_valid_nxt;
      last_idx    <= last_idx_nxt;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [3:0] LIMIT = 4'(TIMEOUT_CYC - 1);

  logic [3:0] cnt, cnt_nxt;
  logic       timeout_nxt;

  assign force_rel = (state == GRANT) && (cnt == LIMIT);

  // Counter sits at zero in IDLE so it starts from zero on every grant entry.
  always_comb begin
    cnt_nxt     = 4'd0;
    timeout_nxt = 1'b0;
    if (state == GRANT) begin
      cnt_nxt     = cnt + 4'd1;
      timeout_nxt = force_rel && !done && req[grant_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= 4'd0;
      timeout <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      timeout <= timeout_nxt;
    end
  end
`else
  assign force_rel = 1'b0;
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: expected outputs queued per step, compared after each edge.
// Builds with or without ARB_TIMEOUT_EN; the timeout scenario adapts to the build.
module tb_rr_arbiter4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0] g;
    logic [1:0] i;
    logic       t;
    string      tag;
  } exp_t;

  exp_t sbq[$];

  rr_arbiter4 #(.TIMEOUT_CYC(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  // Structural invariants sampled mid-cycle.
  always @(negedge clk) begin
    logic [1:0] want_idx;
    want_idx = 2'd0;
    if (grant == 4'b0010) want_idx = 2'd1;
    if (grant == 4'b0100) want_idx = 2'd2;
    if (grant == 4'b1000) want_idx = 2'd3;
    n_assert += 3;
    assert ($onehot0(grant)) else begin
      n_fail++;
      $error("FAIL inv_onehot: observed grant %b, expected at most one bit", grant);
    end
    assert (grant_valid === (|grant)) else begin
      n_fail++;
      $error("FAIL inv_valid: observed %b, expected %b", grant_valid, |grant);
    end
    assert (grant_idx === want_idx) else begin
      n_fail++;
      $error("FAIL inv_idx: observed %0d, expected %0d for grant %b", grant_idx, want_idx, grant);
    end
  end

  task automatic push(input logic [3:0] g, input logic [1:0] i, input logic t, input string tag);
    exp_t e;
    e.g = g; e.i = i; e.t = t; e.tag = tag;
    sbq.push_back(e);
  endtask

  task automatic check_now();
    exp_t e;
    if (sbq.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard: observed empty queue, expected an entry");
      return;
    end
    e = sbq.pop_front();
    n_assert += 4;
    assert (grant === e.g) else begin
      n_fail++;
      $error("FAIL %s grant: observed %b, expected %b", e.tag, grant, e.g);
    end
    assert (grant_idx === e.i) else begin
      n_fail++;
      $error("FAIL %s grant_idx: observed %0d, expected %0d", e.tag, grant_idx, e.i);
    end
    assert (grant_valid === (|e.g)) else begin
      n_fail++;
      $error("FAIL %s grant_valid: observed %b, expected %b", e.tag, grant_valid, |e.g);
    end
    assert (timeout === e.t) else begin
      n_fail++;
      $error("FAIL %s timeout: observed %b, expected %b", e.tag, timeout, e.t);
    end
  endtask

  // Drive inputs for one cycle; expectation describes outputs after the next edge.
  task automatic step(input logic [3:0] r, input logic d, input logic [3:0] eg,
                      input logic [1:0] ei, input logic et, input string tag);
    req  = r;
    done = d;
    push(eg, ei, et, tag);
    @(posedge clk);
    #1;
    check_now();
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    #2;
    push(4'b0000, 2'd0, 1'b0, "reset");
    check_now();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req   = 4'b1111;
    #1;
    push(4'b0000, 2'd0, 1'b0, "deassert_no_grant");
    check_now();

    // Full rotation with done in the second grant cycle; done in IDLE is ignored.
    step(4'b1111, 1'b0, 4'b0001, 2'd0, 1'b0, "rot_g0");
    step(4'b1111, 1'b0, 4'b0001, 2'd0, 1'b0, "rot_g0_hold");
    step(4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, "rot_rel0");
    step(4'b1111, 1'b1, 4'b0010, 2'd1, 1'b0, "rot_g1_idle_done");
    step(4'b1111, 1'b0, 4'b0010, 2'd1, 1'b0, "rot_g1_hold");
    step(4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, "rot_rel1");
    step(4'b1111, 1'b0, 4'b0100, 2'd2, 1'b0, "rot_g2");
    step(4'b1111, 1'b0, 4'b0100, 2'd2, 1'b0, "rot_g2_hold");
    step(4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, "rot_rel2");
    step(4'b1111, 1'b0, 4'b1000, 2'd3, 1'b0, "rot_g3");
    step(4'b1111, 1'b0, 4'b1000, 2'd3, 1'b0, "rot_g3_hold");
    step(4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, "rot_rel3");
    step(4'b1111, 1'b0, 4'b0001, 2'd0, 1'b0, "rot_wrap");
    step(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, "rot_end");
    step(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, "idle_noreq");

    // Other requesters changing while owner 2 holds.
    step(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0, "own2");
    step(4'b1101, 1'b0, 4'b0100, 2'd2, 1'b0, "own2_ignore");
    step(4'b1101, 1'b1, 4'b0000, 2'd0, 1'b0, "own2_rel");
    step(4'b1101, 1'b0, 4'b1000, 2'd3, 1'b0, "own2_next3");
    step(4'b1101, 1'b1, 4'b0000, 2'd0, 1'b0, "own3_rel");
    step(4'b1101, 1'b0, 4'b0001, 2'd0, 1'b0, "own2_next0");
    step(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, "own0_rel");

    // Owner drop releases; last_idx=1 steers 0011 to requester 0.
    step(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0, "own1");
    step(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, "own1_drop");
    step(4'b0011, 1'b0, 4'b0001, 2'd0, 1'b0, "after_drop");
    step(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, "drop0");

    // Release wins over a still-present owner req; sole requester wins again.
    step(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0, "prec_g0");
    step(4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0, "prec_rel");
    step(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0, "prec_sole");
    step(4'b0011, 1'b1, 4'b0000, 2'd0, 1'b0, "prec_rel2");
    step(4'b0011, 1'b0, 4'b0010, 2'd1, 1'b0, "prec_other");
    step(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, "prec_end");

    // Async reset mid-grant (last_idx=1 beforehand).
    step(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0, "rst_own2");
    rst_n = 1'b0;
    #1;
    push(4'b0000, 2'd0, 1'b0, "rst_async_drop");
    check_now();
    step(4'b0100, 1'b0, 4'b0000, 2'd0, 1'b0, "rst_held");
    rst_n = 1'b1;
    step(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0, "rst_regrant");
    step(4'b0100, 1'b1, 4'b0000, 2'd0, 1'b0, "rst_rel");
    step(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0, "rst_own2b");
    rst_n = 1'b0;
    #1;
    push(4'b0000, 2'd0, 1'b0, "rst2_async_drop");
    check_now();
    rst_n = 1'b1;
    step(4'b1010, 1'b0, 4'b0010, 2'd1, 1'b0, "rst_last3");
    step(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, "rst_end");

`ifdef ARB_TIMEOUT_EN
    step(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0, "to_c1");
    step(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0, "to_c2");
    step(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0, "to_c3");
    step(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0, "to_c4");
    step(4'b0001, 1'b0, 4'b0000, 2'd0, 1'b1, "to_fire");
    step(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0, "to_regrant");
    step(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0, "tod_c2");
    step(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0, "tod_c3");
    step(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0, "tod_c4");
    step(4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0, "tod_done_wins");
    step(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, "tod_end");
`else
    step(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0, "nto_c1");
    for (int c = 2; c <= 6; c++) begin
      step(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0, "nto_hold");
    end
    step(4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0, "nto_done");
    step(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, "nto_end");
`endif

    n_assert++;
    assert (sbq.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d entries, expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_arbiter4.md
RR_ARBITER4 -- requirements
Module: rr_arbiter4

Interface
REQ-001 Parameter TIMEOUT_CYC, default 15: maximum GRANT-state cycles before forced release. Range 2..15; meaningful only with ARB_TIMEOUT_EN.
REQ-002 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 Port req, input, 4: request lines; bit i is requester i. Level-sensitive; any combination is allowed.
REQ-005 Port done, input, 1: single-cycle pulse from the current owner ending its tenure.
REQ-006 Port grant, output, 4: one-hot grant, registered; 4'b0000 when no owner.
REQ-007 Port grant_idx, output, 2: binary index of the asserted grant bit, registered; 2'b00 when no owner.
REQ-008 Port grant_valid, output, 1: high exactly when grant is non-zero.
REQ-009 Port timeout, output, 1: single-cycle pulse on forced release.

Function
REQ-010 The FSM SHALL have exactly two states, IDLE and GRANT, encoded in one flop.
REQ-011 In IDLE with req==0, the block SHALL remain in IDLE with all outputs zero.
REQ-012 In IDLE with req!=0, the block SHALL select the first set req bit, searching upward modulo 4 from last_idx+1. It SHALL register grant, grant_idx and grant_valid at the next edge and enter GRANT. Latency is 1 cycle from req sampled to grant visible.
REQ-013 Selection SHALL follow the one-hot-to-binary mapping 0001->00, 0010->01, 0100->10, 1000->11. grant and grant_idx SHALL always be mutually consistent.
REQ-014 In GRANT, outputs SHALL hold stable while the owner's req bit is high and done is low. Changes on other req bits SHALL be ignored.
REQ-015 In GRANT, done=1 or a deasserted owner req bit SHALL release the grant at the next edge: outputs go to zero, last_idx takes the owner index, and the state returns to IDLE.
REQ-016 After every release there SHALL be exactly one IDLE cycle with grant==0 before any new grant (no back-to-back grants).
REQ-017 done asserted in IDLE SHALL be ignored.
REQ-018 If done and a new owner-side req are both present at release, the release SHALL take precedence. The same requester wins the next arbitration only if no other req bit is set.
REQ-019 At most one grant bit SHALL be high in any cycle.
REQ-020 Starvation bound: a continuously asserted req SHALL be granted within 3 intervening tenures.

Reset
REQ-021 rst_n low SHALL immediately and asynchronously force: state=IDLE, grant=0, grant_idx=0, grant_valid=0, timeout=0, last_idx=3 (requester 0 has first priority), timeout counter=0.
REQ-022 Reset asserted mid-GRANT SHALL drop the grant in the same cycle with no release pulse. The first post-reset arbitration SHALL use last_idx=3.
REQ-023 Reset deassertion SHALL NOT itself generate a grant. Arbitration starts at the first clk edge with rst_n high.

Configuration
REQ-024 Macro ARB_TIMEOUT_EN defined: a 4-bit counter clears on entry to GRANT and increments each GRANT cycle.
- When the counter equals TIMEOUT_CYC-1 without done, the block SHALL release as in REQ-015.
- timeout SHALL pulse high for the one cycle coinciding with grant==0 after that release.
- If done arrives in the same cycle the limit is reached, done SHALL win and timeout stays 0.
REQ-025 Macro ARB_TIMEOUT_EN undefined: no counter SHALL be synthesized, timeout SHALL be tied to 0, and GRANT lasts indefinitely until done or owner req drop.

Verification
REQ-026 Reset then req=4'b1111 held, done pulsed each GRANT cycle 2 -> grant sequence 0001,0010,0100,1000,0001, each separated by one grant==0 cycle; grant_idx 0,1,2,3,0.
REQ-027 Owner 2 granted, then req changes 0100->1101 without done -> grant stays 0100. done pulse -> next grant 1000 (idx 3), then 0001.
REQ-028 Owner 1 granted, req[1] dropped -> release next edge, last_idx=1. With req=4'b0011, the next grant is 0001.
REQ-029 rst_n pulled low mid-GRANT (grant=0100) -> grant=0 and grant_valid=0 without waiting for clk. After release with req=4'b0100, grant=0100 one cycle later.
REQ-030 ARB_TIMEOUT_EN defined, TIMEOUT_CYC=4, req=4'b0001 held with no done -> grant high 4 cycles, then grant=0 with timeout=1 for 1 cycle, then re-grant 0001. Repeat with done on cycle 4 -> timeout stays 0.
REQ-031 Assertions throughout all scenarios: $onehot0(grant); grant_valid==|grant; grant_idx matches grant.
